// File: rtl/vc_arb_crossbar_n.sv
// N-in/N-out domain-tagged crossbar with per-output round-robin arbitration,
// a one-entry registered buffer per output and H->L flow blocking.
module vc_arb_crossbar_n #(
    parameter int p_nbits  = 32,
    parameter int p_nports = 3,
    parameter int p_sbits  = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [p_nports-1:0]           in_val,
    output logic [p_nports-1:0]           in_rdy,
    input  logic [p_nports*p_nbits-1:0]   in_msg,
    input  logic [p_nports*p_sbits-1:0]   in_dest,
    input  logic [p_nports-1:0]           in_domain,
    input  logic [p_nports-1:0]           port_domain,
    output logic [p_nports-1:0]           out_val,
    input  logic [p_nports-1:0]           out_rdy,
    output logic [p_nports*p_nbits-1:0]   out_msg,
    output logic [p_nports-1:0]           out_domain,
    output logic                          viol,
    output logic [p_sbits-1:0]            viol_src,
    output logic [7:0]                    viol_count
);

    localparam int N = p_nports;

    // Handshake: a request transfers on a rising edge where in_val[i] && in_rdy[i];
    // an output dequeues where out_val[j] && out_rdy[j]. Requesters seeing
    // in_rdy=0 keep val/msg/dest/domain stable until accepted.

    logic [p_sbits-1:0] dest      [N];
    logic [N-1:0]       legal;
    logic [N-1:0]       illegal;
    logic [N-1:0]       can_accept;
    logic [N-1:0]       have_winner;
    logic [N-1:0]       fire;
    logic [p_sbits-1:0] winner    [N];
    logic [p_sbits-1:0] ptr       [N];
    logic [p_sbits-1:0] ptr_next  [N];
    logic [p_nbits-1:0] win_msg   [N];
    logic [N-1:0]       win_dom;
    logic               viol_next;
    logic [p_sbits-1:0] viol_src_next;
    logic [7:0]         viol_count_next;

    always_comb begin : classify
        logic h_to_l;
        h_to_l = 1'b0;
        for (int i = 0; i < N; i++) begin
            dest[i]    = in_dest[i*p_sbits +: p_sbits];
            legal[i]   = 1'b0;
            illegal[i] = 1'b0;
            h_to_l     = 1'b0;
            // A high-domain message may never reach a low-domain consumer.
            for (int j = 0; j < N; j++) begin
                if (int'(dest[i]) == j && in_domain[i] && !port_domain[j]) begin
                    h_to_l = 1'b1;
                end
            end
            if (in_val[i]) begin
                if (int'(dest[i]) >= N || h_to_l) begin
                    illegal[i] = 1'b1;
                end else begin
                    legal[i] = 1'b1;
                end
            end
        end
    end

    assign can_accept = ~out_val | out_rdy;

    always_comb begin : arbitrate
        int idx;
        idx = 0;
        for (int j = 0; j < N; j++) begin
            have_winner[j] = 1'b0;
            winner[j]      = '0;
            // Search starts at the pointer and wraps, so the last winner goes last.
            for (int k = 0; k < N; k++) begin
                idx = int'(ptr[j]) + k;
                if (idx >= N) begin
                    idx = idx - N;
                end
                if (!have_winner[j] && legal[idx] && int'(dest[idx]) == j) begin
                    have_winner[j] = 1'b1;
                    winner[j]      = p_sbits'(idx);
                end
            end
            fire[j]     = can_accept[j] && have_winner[j];
            ptr_next[j] = (int'(winner[j]) == N - 1) ? '0 : winner[j] + 1'b1;
            win_msg[j]  = in_msg[int'(winner[j])*p_nbits +: p_nbits];
            win_dom[j]  = in_domain[winner[j]];
        end
    end

    always_comb begin : ready_gen
        logic acc;
        acc = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = illegal[i];
            for (int j = 0; j < N; j++) begin
                if (fire[j] && int'(winner[j]) == i) begin
                    acc = 1'b1;
                end
            end
            in_rdy[i] = reset && acc;
        end
    end

    always_comb begin : drop_stats
        int drops;
        int sum;
        drops         = 0;
        sum           = 0;
        viol_src_next = '0;
        // Walk downward so the lowest dropped index is the one reported.
        for (int i = N - 1; i >= 0; i--) begin
            if (illegal[i]) begin
                viol_src_next = p_sbits'(i);
                drops         = drops + 1;
            end
        end
        viol_next       = (drops != 0);
        sum             = int'(viol_count) + drops;
        viol_count_next = (sum > 255) ? 8'd255 : 8'(sum);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_val    <= '0;
            out_msg    <= '0;
            out_domain <= '0;
            viol       <= 1'b0;
            viol_src   <= '0;
            viol_count <= '0;
            for (int j = 0; j < N; j++) begin
                ptr[j] <= '0;
            end
        end else begin
            for (int j = 0; j < N; j++) begin
                if (fire[j]) begin
                    out_val[j]                   <= 1'b1;
                    out_msg[j*p_nbits +: p_nbits] <= win_msg[j];
                    out_domain[j]                <= win_dom[j];
                    ptr[j]                       <= ptr_next[j];
                end else if (out_val[j] && out_rdy[j]) begin
                    out_val[j] <= 1'b0;
                end
            end
            viol       <= viol_next;
            viol_src   <= viol_next ? viol_src_next : '0;
            viol_count <= viol_count_next;
        end
    end

endmodule
